bitplane_seq_mux: RTL

//   Parametrised, sequenced successor to the fixed 8:1 bit-plane select mux.
//   - Steps through NPLANE bit-planes of the register array on its own, one plane per accepted beat.
//   - The programmable precision PREC sets how many planes are sent; MSB_FIRST sets the order.
//   - Output is a registered valid/ready stream into the bit-serial compute array.
//   - Replaces the external 3-bit CTRL select counter.

---
 rtl/bitplane_seq_mux.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/bitplane_seq_mux.sv
// -----------------------------------------------------------------------------
// bitplane_seq_mux
//
// Purpose:
//   Sequenced bit-plane selector. On i_start it latches a (clamped) precision N
//   and an order flag, then streams N planes of the register array out of a
//   registered valid/ready port, one plane per accepted beat. Walks indices
//   0..N-1 (LSB first) or N-1..0 (MSB first). Replaces an external select
//   counter driving a fixed 8:1 mux.
//
// Parameters:
//   DW      bits per lane in one plane
//   LANES   lanes per plane (plane width PLW = DW*LANES)
//   NPLANE  number of bit-planes, >= 2
//
// Ports:
//   i_clk               clock, rising edge
//   i_rst               asynchronous reset, active-high
//   i_reg_array_planes  NPLANE*PLW; plane p = bits [p*PLW +: PLW], stable while busy
//   i_prec              PW+1 bits; planes to send, 0 or >NPLANE clamps to NPLANE
//   i_msb_first         1: plane N-1 down to 0; 0: plane 0 up to N-1
//   i_start             start a sequence (honoured only in IDLE)
//   i_out_ready         downstream accepts the current beat
//   o_out_valid         o_reg_array_out holds a valid plane
//   o_reg_array_out     selected plane (registered, holds when not valid)
//   o_plane_idx         index of the plane on o_reg_array_out
//   o_last              current beat is the final plane of the sequence
//   o_busy              high from the cycle after start until the final handshake
//   o_done              one-cycle pulse after the final handshake
//   o_is_sign           (BITPLANE_SIGN_FLAG_EN only) current plane is index N-1
//
// Configuration macro:
//   BITPLANE_SIGN_FLAG_EN  adds the registered o_is_sign output.
// -----------------------------------------------------------------------------
module bitplane_seq_mux #(
  parameter int DW     = 128,
  parameter int LANES  = 9,
  parameter int NPLANE = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NPLANE*DW*LANES-1:0]          i_reg_array_planes,
  input  logic [$clog2(NPLANE):0]             i_prec,
  input  logic                                i_msb_first,
  input  logic                                i_start,
  input  logic                                i_out_ready,
  output logic                                o_out_valid,
  output logic [DW*LANES-1:0]                 o_reg_array_out,
  output logic [$clog2(NPLANE)-1:0]           o_plane_idx,
  output logic                                o_last,
  output logic                                o_busy,
  output logic                                o_done
`ifdef BITPLANE_SIGN_FLAG_EN
  ,
  output logic                                o_is_sign
`endif
);

  localparam int PLW = DW * LANES;
  localparam int PW  = $clog2(NPLANE);
  localparam logic [PW:0] NPLANE_W = (PW+1)'(NPLANE);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Sequence context latched on start
  logic [PW:0]     r_n;
  logic            r_msb_first;

  // Output registers
  logic            r_valid;
  logic [PLW-1:0]  r_data;
  logic [PW-1:0]   r_idx;
  logic            r_last;
  logic            r_busy;
  logic            r_done;
`ifdef BITPLANE_SIGN_FLAG_EN
  logic            r_is_sign;
`endif

  // Next-state values
  logic [PW:0]     w_n_next;
  logic            w_msb_next;
  logic            w_valid_next;
  logic [PW-1:0]   w_idx_next;
  logic            w_last_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic            w_load;

  // Plane slicing of the flat input bus
  logic [PLW-1:0]  w_planes [NPLANE];

  generate
    for (genvar gi = 0; gi < NPLANE; gi++) begin : g_plane
      assign w_planes[gi] = i_reg_array_planes[gi*PLW +: PLW];
    end
  endgenerate

  // Clamp of the requested precision: 0 and anything above NPLANE mean "all planes"
  logic [PW:0]     w_n_start;
  logic [PW:0]     w_n_start_m1;
  logic [PW-1:0]   w_first_idx;

  assign w_n_start    = ((i_prec == '0) || (i_prec > NPLANE_W)) ? NPLANE_W : i_prec;
  assign w_n_start_m1 = w_n_start - (PW+1)'(1);
  assign w_first_idx  = i_msb_first ? w_n_start_m1[PW-1:0] : '0;

  // Index of the following plane and whether it terminates the sequence
  logic [PW-1:0]   w_step_idx;
  logic [PW:0]     w_n_m1;
  logic            w_step_is_last;

  assign w_n_m1         = r_n - (PW+1)'(1);
  assign w_step_idx     = r_msb_first ? (r_idx - PW'(1)) : (r_idx + PW'(1));
  assign w_step_is_last = r_msb_first ? (w_step_idx == '0)
                                      : ({1'b0, w_step_idx} == w_n_m1);

  wire w_handshake = r_valid & i_out_ready;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_next = r_state;
    w_n_next     = r_n;
    w_msb_next   = r_msb_first;
    w_valid_next = r_valid;
    w_idx_next   = r_idx;
    w_last_next  = r_last;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_load       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_n_next     = w_n_start;
          w_msb_next   = i_msb_first;
          w_idx_next   = w_first_idx;
          w_last_next  = (w_n_start == (PW+1)'(1));
          w_valid_next = 1'b1;
          w_busy_next  = 1'b1;
          w_load       = 1'b1;
          w_state_next = S_STREAM;
        end
      end

      S_STREAM: begin
        if (w_handshake) begin
          if (r_last) begin
            // Final beat accepted: drop valid, pulse done; index and data hold
            w_valid_next = 1'b0;
            w_busy_next  = 1'b0;
            w_last_next  = 1'b0;
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_idx_next  = w_step_idx;
            w_last_next = w_step_is_last;
            w_load      = 1'b1;
          end
        end
        // Without a handshake everything holds (backpressure)
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_n         <= '0;
      r_msb_first <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_n         <= w_n_next;
      r_msb_first <= w_msb_next;
      r_valid     <= w_valid_next;
      r_idx       <= w_idx_next;
      r_last      <= w_last_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      if (w_load) begin
        r_data <= w_planes[w_idx_next];
      end
    end
  end

`ifdef BITPLANE_SIGN_FLAG_EN
  // Sign plane is the top plane of the active precision; refreshed only when
  // a new plane is loaded so it holds together with the index.
  logic [PW:0] w_n_next_m1;
  assign w_n_next_m1 = w_n_next - (PW+1)'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_is_sign <= 1'b0;
    end else if (w_load) begin
      r_is_sign <= ({1'b0, w_idx_next} == w_n_next_m1);
    end
  end

  assign o_is_sign = r_is_sign;
`endif

  assign o_out_valid     = r_valid;
  assign o_reg_array_out = r_data;
  assign o_plane_idx     = r_idx;
  assign o_last          = r_last;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule
